jam_cost_arbiter: RTL

Shares the single cost-ROM port of the job-assignment engine (3-bit worker address W, 3-bit job address J, 7-bit Cost returned from the ROM's registered address) among NREQ independent requesters, e.g. parallel permutation evaluators. Uses round-robin arbitration with a valid/ready-style grant. Issues at most one ROM access per cycle, fully pipelined. Routes each returned Cost to the requester that issued the access. Sits between the evaluator lanes and the cost ROM interface at the JAM top level.

---
 rtl/jam_cost_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/jam_cost_arbiter.sv
// Round-robin arbiter sharing the JAM cost-ROM port among NREQ requesters, with id-tagged response routing.
// Optional macro JAM_COST_ARB_RSP_REG_EN registers the returned cost (one extra cycle of latency).
module jam_cost_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] req_w,
    input  logic [3*NREQ-1:0] req_j,
    output logic [NREQ-1:0]   gnt,
    output logic [2:0]        W,
    output logic [2:0]        J,
    input  logic [6:0]        Cost,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [6:0]        rsp_cost,
    output logic              busy
);

`ifdef JAM_COST_ARB_RSP_REG_EN
    localparam int NSTG = 3;
`else
    localparam int NSTG = 2;
`endif

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  nxt_ptr;
    logic            win_found;
    logic            accept;
    logic [2:0]      sel_w;
    logic [2:0]      sel_j;
    logic [NSTG-1:0] tag_vld;
    logic [IDW-1:0]  tag_id [NSTG];

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        sel_w     = '0;
        sel_j     = '0;
        for (int s = 0; s < NREQ; s++) begin
            int k;
            k = int'(ptr) + s;
            if (k >= NREQ) k = k - NREQ;
            if (!win_found && req[k]) begin
                win_found = 1'b1;
                win_id    = IDW'(k);
                sel_w     = req_w[3*k +: 3];
                sel_j     = req_j[3*k +: 3];
            end
        end
    end

    assign accept  = win_found && !RST;
    assign nxt_ptr = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++)
            gnt[i] = accept && (win_id == IDW'(i));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= '0;
            W   <= '0;
            J   <= '0;
        end else if (accept) begin
            ptr <= nxt_ptr;
            W   <= sel_w;
            J   <= sel_j;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) tag_vld <= '0;
        else     tag_vld <= {tag_vld[NSTG-2:0], accept};
    end

    // NOTE: tag ids are not reset; they are only ever interpreted under their valid bit.
    always_ff @(posedge CLK) begin
        tag_id[0] <= win_id;
        for (int s = 1; s < NSTG; s++)
            tag_id[s] <= tag_id[s-1];
    end

    // Gating with RST drops the response of an access still in flight when reset arrives.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++)
            rsp_valid[i] = tag_vld[NSTG-1] && !RST && (tag_id[NSTG-1] == IDW'(i));
    end

    assign busy = |tag_vld;

`ifdef JAM_COST_ARB_RSP_REG_EN
    logic [6:0] cost_q;
    always_ff @(posedge CLK) begin
        if (RST) cost_q <= '0;
        else     cost_q <= Cost;
    end
    assign rsp_cost = cost_q;
`else
    assign rsp_cost = Cost;
`endif

endmodule
